// File: rtl/cmp_pkg.sv
// Shared region/state encodings for the comparator event tracker.
// Region codes are ordered so that a numeric compare gives LESS < EQUAL < GREATER.
package cmp_pkg;

  localparam logic [1:0] REG_NONE    = 2'b00;
  localparam logic [1:0] REG_LESS    = 2'b01;
  localparam logic [1:0] REG_EQUAL   = 2'b10;
  localparam logic [1:0] REG_GREATER = 2'b11;

  // State encoding deliberately matches the region codes (UNKNOWN aliases NONE).
  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StLess    = 2'b01,
    StEqual   = 2'b10,
    StGreater = 2'b11
  } state_e;

  function automatic logic [1:0] flags_to_region(input logic a_greater,
                                                 input logic a_equal,
                                                 input logic a_less);
    logic [1:0] region;
    case ({a_greater, a_equal, a_less})
      3'b001:  region = REG_LESS;
      3'b010:  region = REG_EQUAL;
      3'b100:  region = REG_GREATER;
      default: region = REG_NONE;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/cmp_event_fifo_slot.sv
// One-entry event holding register with valid/ready handshake.
// A push that finds the slot occupied and not draining is dropped and flagged.
module cmp_event_fifo_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       push_up,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] code,
  output logic       up,
  output logic       ovf_sticky
);

  logic accept;
  assign accept = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      code       <= 2'b00;
      up         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      valid      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (push) begin
      if (!valid || accept) begin
        valid <= 1'b1;
        code  <= push_code;
        up    <= push_up;
      end else begin
        // Pending payload is left untouched; only the loss is recorded.
        ovf_sticky <= 1'b1;
      end
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmp_event_tracker.sv
// Debounces magnitude-comparator flags into a committed region and reports
// region changes as handshaked events with a saturating crossing count.
module cmp_event_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             a_greater,
  input  logic             a_equal,
  input  logic             a_less,
  input  logic             clr,
  output logic             state_less,
  output logic             state_equal,
  output logic             state_greater,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_up,
  output logic [1:0]       evt_code,
  output logic [CNT_W-1:0] cross_cnt,
  output logic             err_sticky,
  output logic             ovf_sticky
);

  localparam logic [3:0] StableMax = 4'(STABLE_CNT);

  state_e     state_q;
  logic [1:0] state_bits;
  logic [1:0] sample_region;
  logic [1:0] cand_q, cand_d;
  logic [3:0] stab_q, stab_d;
  logic       sample_bad;
  logic       commit;
  logic       crossing;
  logic       evt_gen;
  logic       evt_up_d;

  assign state_bits    = state_q;
  assign sample_region = flags_to_region(a_greater, a_equal, a_less);

  always_comb begin
    cand_d     = cand_q;
    stab_d     = stab_q;
    sample_bad = 1'b0;
    if (sample_valid) begin
      if (sample_region == REG_NONE) begin
        sample_bad = 1'b1;
        cand_d     = REG_NONE;
        stab_d     = 4'd0;
      end else if (sample_region == cand_q) begin
        stab_d = (stab_q >= StableMax) ? StableMax : stab_q + 4'd1;
      end else begin
        cand_d = sample_region;
        stab_d = 4'd1;
      end
    end
  end

  always_comb begin
    commit   = sample_valid && !sample_bad && (stab_d == StableMax) && (cand_d != state_bits);
    // Acquisition out of UNKNOWN is not a crossing.
    crossing = commit && (state_q != StUnknown);
    evt_gen  = crossing && !clr;
    evt_up_d = cand_d > state_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StUnknown;
      state_less    <= 1'b0;
      state_equal   <= 1'b0;
      state_greater <= 1'b0;
    end else if (commit) begin
      state_q       <= state_e'(cand_d);
      state_less    <= (cand_d == REG_LESS);
      state_equal   <= (cand_d == REG_EQUAL);
      state_greater <= (cand_d == REG_GREATER);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= REG_NONE;
      stab_q <= 4'd0;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cross_cnt  <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      cross_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (crossing && (cross_cnt != {CNT_W{1'b1}})) begin
        cross_cnt <= cross_cnt + 1'b1;
      end
      if (sample_bad) begin
        err_sticky <= 1'b1;
      end
    end
  end

  cmp_event_fifo_slot u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push       (evt_gen),
    .push_code  (cand_d),
    .push_up    (evt_up_d),
    .ready      (evt_ready),
    .valid      (evt_valid),
    .code       (evt_code),
    .up         (evt_up),
    .ovf_sticky (ovf_sticky)
  );

endmodule

// File: tb/tb_cmp_event_tracker.sv
// Scoreboard bench for cmp_event_tracker: expected events are queued as stimulus
// is driven and compared when the DUT hands them over.
module tb_cmp_event_tracker;

  localparam logic [2:0] F_L = 3'b001;
  localparam logic [2:0] F_E = 3'b010;
  localparam logic [2:0] F_G = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_valid = 1'b0;
  logic a_greater = 1'b0, a_equal = 1'b0, a_less = 1'b0;
  logic clr = 1'b0;
  logic evt_ready = 1'b0;

  logic       state_less, state_equal, state_greater;
  logic       evt_valid, evt_up, err_sticky, ovf_sticky;
  logic [1:0] evt_code;
  logic [7:0] cross_cnt;

  logic       s_state_less, s_state_equal, s_state_greater;
  logic       s_evt_valid, s_evt_up, s_err_sticky, s_ovf_sticky;
  logic [1:0] s_evt_code;
  logic [1:0] s_cross_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] code;
    logic       up;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;

  always #5 clk = ~clk;

  cmp_event_tracker #(.STABLE_CNT(4), .CNT_W(8)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .a_greater     (a_greater),
    .a_equal       (a_equal),
    .a_less        (a_less),
    .clr           (clr),
    .state_less    (state_less),
    .state_equal   (state_equal),
    .state_greater (state_greater),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_up        (evt_up),
    .evt_code      (evt_code),
    .cross_cnt     (cross_cnt),
    .err_sticky    (err_sticky),
    .ovf_sticky    (ovf_sticky)
  );

  cmp_event_tracker #(.STABLE_CNT(4), .CNT_W(2)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .a_greater     (a_greater),
    .a_equal       (a_equal),
    .a_less        (a_less),
    .clr           (clr),
    .state_less    (s_state_less),
    .state_equal   (s_state_equal),
    .state_greater (s_state_greater),
    .evt_valid     (s_evt_valid),
    .evt_ready     (evt_ready),
    .evt_up        (s_evt_up),
    .evt_code      (s_evt_code),
    .cross_cnt     (s_cross_cnt),
    .err_sticky    (s_err_sticky),
    .ovf_sticky    (s_ovf_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [2:0] f);
    {a_greater, a_equal, a_less} = f;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic smp_n(input logic [2:0] f, input int n);
    for (int i = 0; i < n; i++) smp(f);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake completes on the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("evt_code", 32'(evt_code), 32'(mon_e.code));
        check("evt_up", 32'(evt_up), 32'(mon_e.up));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    check("rst_state", {state_less, state_equal, state_greater}, 3'b000);
    check("rst_evt", {evt_valid, evt_up, evt_code}, 4'b0000);
    check("rst_cross", cross_cnt, 0);
    check("rst_sticky", {err_sticky, ovf_sticky}, 2'b00);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Acquire LESS; a gap in the middle must not break stability
    smp_n(F_L, 2);
    idle(2);
    smp(F_L);
    check("less_not_yet", state_less, 1'b0);
    smp(F_L);
    check("less_acq", {state_less, state_equal, state_greater}, 3'b100);
    check("acq_no_evt", evt_valid, 1'b0);
    check("acq_no_cnt", cross_cnt, 0);

    // Interrupted run, then a clean run to GREATER
    smp_n(F_G, 3);
    smp(F_L);
    smp_n(F_G, 3);
    check("gt_not_yet", {state_less, state_equal, state_greater}, 3'b100);
    exp_q.push_back('{code: 2'b11, up: 1'b1});
    smp(F_G);
    check("gt_commit", {state_less, state_equal, state_greater}, 3'b001);
    check("gt_evt_valid", evt_valid, 1'b1);
    check("gt_evt_payload", {evt_code, evt_up}, 3'b111);
    check("gt_cross", cross_cnt, 1);

    // Second transition while the first is still pending -> dropped
    smp_n(F_E, 4);
    check("eq_commit", {state_less, state_equal, state_greater}, 3'b010);
    check("ovf_set", ovf_sticky, 1'b1);
    check("ovf_payload_held", {evt_valid, evt_code, evt_up}, 4'b1111);
    check("ovf_cross", cross_cnt, 2);
    evt_ready = 1'b1;
    idle(1);
    evt_ready = 1'b0;
    check("accept_drop_valid", evt_valid, 1'b0);

    // Invalid flag sets restart debouncing
    smp_n(F_G, 2);
    smp(3'b110);
    check("err_set", err_sticky, 1'b1);
    smp(3'b000);
    smp_n(F_G, 3);
    check("err_restart", {state_less, state_equal, state_greater}, 3'b010);
    exp_q.push_back('{code: 2'b11, up: 1'b1});
    smp(F_G);
    check("err_then_commit", {state_less, state_equal, state_greater}, 3'b001);
    check("cross_3", cross_cnt, 3);
    check("sat_cross_3", s_cross_cnt, 2'd3);

    // Five more crossings with the consumer always ready
    evt_ready = 1'b1;
    exp_q.push_back('{code: 2'b01, up: 1'b0});
    smp_n(F_L, 4);
    exp_q.push_back('{code: 2'b10, up: 1'b1});
    smp_n(F_E, 4);
    exp_q.push_back('{code: 2'b01, up: 1'b0});
    smp_n(F_L, 4);
    exp_q.push_back('{code: 2'b11, up: 1'b1});
    smp_n(F_G, 4);
    exp_q.push_back('{code: 2'b10, up: 1'b0});
    smp_n(F_E, 4);
    idle(2);
    check("cross_8", cross_cnt, 8);
    check("sat_hold", s_cross_cnt, 2'd3);
    check("all_events_taken", exp_q.size(), 0);
    evt_ready = 1'b0;

    // clr: counters and stickies clear, region retained
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_cross", cross_cnt, 0);
    check("clr_sat_cross", s_cross_cnt, 2'd0);
    check("clr_sticky", {err_sticky, ovf_sticky, s_err_sticky, s_ovf_sticky}, 4'b0000);
    check("clr_state_kept", {state_less, state_equal, state_greater}, 3'b010);

    // Async reset mid-debounce with an event pending (never delivered)
    smp_n(F_L, 4);
    check("pre_rst_pending", evt_valid, 1'b1);
    check("pre_rst_cross", cross_cnt, 1);
    smp_n(F_G, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {state_less, state_equal, state_greater}, 3'b000);
    check("arst_evt", {evt_valid, evt_code, evt_up}, 4'b0000);
    check("arst_cross", cross_cnt, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reacquisition from UNKNOWN needs a full run and yields no event
    smp_n(F_G, 3);
    check("reacq_not_yet", {state_less, state_equal, state_greater}, 3'b000);
    smp(F_G);
    check("reacq_state", {state_less, state_equal, state_greater}, 3'b001);
    check("reacq_no_evt", evt_valid, 1'b0);
    check("reacq_cross", cross_cnt, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
